// File: rtl/pipe_control.sv
// pipe_control: control path for the 5-stage RV32I pipeline.
// Decodes the ID instruction, carries the control bundle through ID/EX,
// EX/MEM and MEM/WB, and resolves load-use stalls, redirect flushes and
// EX-stage operand forwarding.
module pipe_control #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int FWD_EN         = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [6:0]                op,
  input  logic [2:0]                funct3,
  input  logic                      funct7,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      ex_eq,
  output logic [1:0]                imm_src,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      pc_src,
  output logic                      ex_reg_write,
  output logic                      ex_mem_write,
  output logic                      ex_alu_src,
  output logic                      ex_branch,
  output logic                      ex_jump,
  output logic [1:0]                ex_result_src,
  output logic [ALU_CTRL_WIDTH-1:0] ex_alu_ctrl,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic                      mem_reg_write,
  output logic                      mem_mem_write,
  output logic [1:0]                mem_result_src,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic                      wb_reg_write,
  output logic [1:0]                wb_result_src,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      ex_illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(0);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(1);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(2);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(5);

  localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

  // ALU operation for R-type and I-ALU; sub_en is only set for R-type
  function automatic logic [ALU_CTRL_WIDTH-1:0] alu_op(input logic [2:0] f3,
                                                       input logic       sub_en);
    case (f3)
      3'b000:  return sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b010:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // ID decode results
  logic                      dec_reg_write;
  logic                      dec_mem_write;
  logic                      dec_alu_src;
  logic                      dec_branch;
  logic                      dec_jump;
  logic [1:0]                dec_result_src;
  logic [ALU_CTRL_WIDTH-1:0] dec_alu_ctrl;
  logic [1:0]                dec_imm_src;
  logic                      dec_legal;
  logic                      dec_illegal;

  // ID/EX register
  logic                      ex_reg_write_q,  ex_reg_write_d;
  logic                      ex_mem_write_q,  ex_mem_write_d;
  logic                      ex_alu_src_q,    ex_alu_src_d;
  logic                      ex_branch_q,     ex_branch_d;
  logic                      ex_jump_q,       ex_jump_d;
  logic [1:0]                ex_result_src_q, ex_result_src_d;
  logic [ALU_CTRL_WIDTH-1:0] ex_alu_ctrl_q,   ex_alu_ctrl_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_q,         ex_rd_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_q,        ex_rs1_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_q,        ex_rs2_d;
  logic                      ex_funct3_0_q,   ex_funct3_0_d;
  logic                      ex_illegal_q,    ex_illegal_d;

  // EX/MEM register
  logic                      mem_reg_write_q,  mem_reg_write_d;
  logic                      mem_mem_write_q,  mem_mem_write_d;
  logic [1:0]                mem_result_src_q, mem_result_src_d;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_q,         mem_rd_d;

  // MEM/WB register
  logic                      wb_reg_write_q,  wb_reg_write_d;
  logic [1:0]                wb_result_src_q, wb_result_src_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q,         wb_rd_d;

  // hazard terms
  logic ex_hit;
  logic mem_hit;
  logic load_use;
  logic raw_stall;
  logic stall;

  // Decode the ID instruction into a control bundle; bubbles and unknown opcodes give all zeros
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_result_src = 2'b00;
    dec_alu_ctrl   = ALU_ADD;
    dec_imm_src    = 2'b00;
    dec_legal      = 1'b0;
    if (id_valid) begin
      dec_legal = 1'b1;
      case (op)
        OP_LW: begin
          dec_reg_write  = 1'b1;
          dec_alu_src    = 1'b1;
          dec_result_src = 2'b01;
        end
        OP_SW: begin
          dec_mem_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_imm_src   = 2'b01;
        end
        OP_R: begin
          dec_reg_write = 1'b1;
          dec_alu_ctrl  = alu_op(funct3, funct7);
        end
        OP_I: begin
          dec_reg_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_alu_ctrl  = alu_op(funct3, 1'b0);
        end
        OP_BR: begin
          dec_branch   = 1'b1;
          dec_alu_ctrl = ALU_SUB;
          dec_imm_src  = 2'b10;
        end
        OP_JAL: begin
          dec_jump       = 1'b1;
          dec_reg_write  = 1'b1;
          dec_result_src = 2'b10;
          dec_imm_src    = 2'b11;
        end
        default: dec_legal = 1'b0;
      endcase
    end
    dec_illegal = id_valid & ~dec_legal;
  end

  assign imm_src = dec_imm_src;

  // Redirect, load-use and (without forwarding) RAW stall resolution; a taken redirect wins
  always_comb begin
    ex_hit    = ex_reg_write_q && (ex_rd_q != X0) &&
                ((ex_rd_q == rs1) || (ex_rd_q == rs2));
    mem_hit   = mem_reg_write_q && (mem_rd_q != X0) &&
                ((mem_rd_q == rs1) || (mem_rd_q == rs2));
    load_use  = id_valid && (ex_result_src_q == 2'b01) && ex_hit;
    raw_stall = (FWD_EN == 0) && id_valid && (ex_hit || mem_hit);
    pc_src    = ex_jump_q | (ex_branch_q & (ex_eq ^ ex_funct3_0_q));
    stall     = (load_use | raw_stall) & ~pc_src;
    stall_f   = stall;
    stall_d   = stall;
    flush_d   = pc_src;
    flush_e   = pc_src | stall;
  end

  // EX operand forwarding: MEM result beats WB result, x0 never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (mem_reg_write_q && (mem_rd_q != X0) && (mem_rd_q == ex_rs1_q))
        fwd_a = 2'b10;
      else if (wb_reg_write_q && (wb_rd_q != X0) && (wb_rd_q == ex_rs1_q))
        fwd_a = 2'b01;
      if (mem_reg_write_q && (mem_rd_q != X0) && (mem_rd_q == ex_rs2_q))
        fwd_b = 2'b10;
      else if (wb_reg_write_q && (wb_rd_q != X0) && (wb_rd_q == ex_rs2_q))
        fwd_b = 2'b01;
    end
  end

  // Next-state for the pipeline registers: ID/EX takes a bubble on flush_e, later stages always advance
  always_comb begin
    ex_reg_write_d  = 1'b0;
    ex_mem_write_d  = 1'b0;
    ex_alu_src_d    = 1'b0;
    ex_branch_d     = 1'b0;
    ex_jump_d       = 1'b0;
    ex_result_src_d = 2'b00;
    ex_alu_ctrl_d   = ALU_ADD;
    ex_rd_d         = X0;
    ex_rs1_d        = X0;
    ex_rs2_d        = X0;
    ex_funct3_0_d   = 1'b0;
    ex_illegal_d    = 1'b0;
    if (!flush_e) begin
      ex_reg_write_d  = dec_reg_write;
      ex_mem_write_d  = dec_mem_write;
      ex_alu_src_d    = dec_alu_src;
      ex_branch_d     = dec_branch;
      ex_jump_d       = dec_jump;
      ex_result_src_d = dec_result_src;
      ex_alu_ctrl_d   = dec_alu_ctrl;
      ex_rd_d         = dec_legal ? rd  : X0;
      ex_rs1_d        = dec_legal ? rs1 : X0;
      ex_rs2_d        = dec_legal ? rs2 : X0;
      ex_funct3_0_d   = dec_legal & funct3[0];
      ex_illegal_d    = dec_illegal;
    end
    mem_reg_write_d  = ex_reg_write_q;
    mem_mem_write_d  = ex_mem_write_q;
    mem_result_src_d = ex_result_src_q;
    mem_rd_d         = ex_rd_q;
    wb_reg_write_d   = mem_reg_write_q;
    wb_result_src_d  = mem_result_src_q;
    wb_rd_d          = mem_rd_q;
  end

  // Pipeline registers; reset drops every in-flight instruction to a NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg_write_q   <= 1'b0;
      ex_mem_write_q   <= 1'b0;
      ex_alu_src_q     <= 1'b0;
      ex_branch_q      <= 1'b0;
      ex_jump_q        <= 1'b0;
      ex_result_src_q  <= 2'b00;
      ex_alu_ctrl_q    <= ALU_ADD;
      ex_rd_q          <= X0;
      ex_rs1_q         <= X0;
      ex_rs2_q         <= X0;
      ex_funct3_0_q    <= 1'b0;
      ex_illegal_q     <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_result_src_q <= 2'b00;
      mem_rd_q         <= X0;
      wb_reg_write_q   <= 1'b0;
      wb_result_src_q  <= 2'b00;
      wb_rd_q          <= X0;
    end else begin
      ex_reg_write_q   <= ex_reg_write_d;
      ex_mem_write_q   <= ex_mem_write_d;
      ex_alu_src_q     <= ex_alu_src_d;
      ex_branch_q      <= ex_branch_d;
      ex_jump_q        <= ex_jump_d;
      ex_result_src_q  <= ex_result_src_d;
      ex_alu_ctrl_q    <= ex_alu_ctrl_d;
      ex_rd_q          <= ex_rd_d;
      ex_rs1_q         <= ex_rs1_d;
      ex_rs2_q         <= ex_rs2_d;
      ex_funct3_0_q    <= ex_funct3_0_d;
      ex_illegal_q     <= ex_illegal_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_result_src_q <= mem_result_src_d;
      mem_rd_q         <= mem_rd_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_result_src_q  <= wb_result_src_d;
      wb_rd_q          <= wb_rd_d;
    end
  end

  assign ex_reg_write   = ex_reg_write_q;
  assign ex_mem_write   = ex_mem_write_q;
  assign ex_alu_src     = ex_alu_src_q;
  assign ex_branch      = ex_branch_q;
  assign ex_jump        = ex_jump_q;
  assign ex_result_src  = ex_result_src_q;
  assign ex_alu_ctrl    = ex_alu_ctrl_q;
  assign ex_rd          = ex_rd_q;
  assign ex_illegal     = ex_illegal_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign mem_mem_write  = mem_mem_write_q;
  assign mem_result_src = mem_result_src_q;
  assign mem_rd         = mem_rd_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign wb_result_src  = wb_result_src_q;
  assign wb_rd          = wb_rd_q;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: table-driven decode/latency checks with a pipeline
// scoreboard, plus hand-written hazard, redirect and reset sequences.
// dut has forwarding enabled; dut0 is the stall-only variant.
module tb_pipe_control;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic [4:0] rs1, rs2, rd;
  logic       ex_eq;

  logic [1:0] imm_src, ex_result_src, mem_result_src, wb_result_src, fwd_a, fwd_b;
  logic       stall_f, stall_d, flush_d, flush_e, pc_src;
  logic       ex_reg_write, ex_mem_write, ex_alu_src, ex_branch, ex_jump, ex_illegal;
  logic [2:0] ex_alu_ctrl;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       mem_reg_write, mem_mem_write, wb_reg_write;

  logic [1:0] z_imm_src, z_ex_result_src, z_mem_result_src, z_wb_result_src, z_fwd_a, z_fwd_b;
  logic       z_stall_f, z_stall_d, z_flush_d, z_flush_e, z_pc_src;
  logic       z_ex_reg_write, z_ex_mem_write, z_ex_alu_src, z_ex_branch, z_ex_jump, z_ex_illegal;
  logic [2:0] z_ex_alu_ctrl;
  logic [4:0] z_ex_rd, z_mem_rd, z_wb_rd;
  logic       z_mem_reg_write, z_mem_mem_write, z_wb_reg_write;

  pipe_control #(.REG_ADDR_WIDTH(5), .ALU_CTRL_WIDTH(3), .FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op(op), .funct3(funct3),
    .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .ex_eq(ex_eq),
    .imm_src(imm_src), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .pc_src(pc_src), .ex_reg_write(ex_reg_write),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_result_src(ex_result_src), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_rd(ex_rd), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_reg_write(mem_reg_write),
    .mem_mem_write(mem_mem_write), .mem_result_src(mem_result_src), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src), .wb_rd(wb_rd),
    .ex_illegal(ex_illegal)
  );

  pipe_control #(.REG_ADDR_WIDTH(5), .ALU_CTRL_WIDTH(3), .FWD_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op(op), .funct3(funct3),
    .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .ex_eq(ex_eq),
    .imm_src(z_imm_src), .stall_f(z_stall_f), .stall_d(z_stall_d), .flush_d(z_flush_d),
    .flush_e(z_flush_e), .pc_src(z_pc_src), .ex_reg_write(z_ex_reg_write),
    .ex_mem_write(z_ex_mem_write), .ex_alu_src(z_ex_alu_src), .ex_branch(z_ex_branch),
    .ex_jump(z_ex_jump), .ex_result_src(z_ex_result_src), .ex_alu_ctrl(z_ex_alu_ctrl),
    .ex_rd(z_ex_rd), .fwd_a(z_fwd_a), .fwd_b(z_fwd_b), .mem_reg_write(z_mem_reg_write),
    .mem_mem_write(z_mem_mem_write), .mem_result_src(z_mem_result_src), .mem_rd(z_mem_rd),
    .wb_reg_write(z_wb_reg_write), .wb_result_src(z_wb_result_src), .wb_rd(z_wb_rd),
    .ex_illegal(z_ex_illegal)
  );

  typedef struct {
    logic       v;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] imm;
    logic       rw, mw, as, br, jp;
    logic [1:0] rsrc;
    logic [2:0] alu;
    logic [4:0] erd;
    logic       ill;
    logic       pc;
  } vec_t;

  typedef struct {
    logic       rw, mw, as, br, jp;
    logic [1:0] rsrc;
    logic [2:0] alu;
    logic [4:0] rd;
    logic       ill;
  } exp_t;

  localparam int NV = 17;
  vec_t tbl[NV];
  exp_t pipe_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d);
    id_valid = v;
    op       = o;
    funct3   = f3;
    funct7   = f7;
    rs1      = a;
    rs2      = b;
    rd       = d;
  endtask

  task automatic bubbles(input int n);
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (n) tick();
  endtask

  initial begin
    vec_t t;
    exp_t e;
    int   n;

    //            v     op           f3      f7    rs1   rs2   rd     imm    rw    mw    as    br    jp    rsrc   alu     erd    ill   pc
    tbl[0]  = '{1'b1, 7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5,  2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b000, 5'd5,  1'b0, 1'b0};
    tbl[1]  = '{1'b1, 7'b0100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd4,  2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 5'd4,  1'b0, 1'b0};
    tbl[2]  = '{1'b1, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd6,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd6,  1'b0, 1'b0};
    tbl[3]  = '{1'b1, 7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd7,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b001, 5'd7,  1'b0, 1'b0};
    tbl[4]  = '{1'b1, 7'b0110011, 3'b111, 1'b0, 5'd1, 5'd2, 5'd8,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 5'd8,  1'b0, 1'b0};
    tbl[5]  = '{1'b1, 7'b0110011, 3'b110, 1'b0, 5'd1, 5'd2, 5'd9,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b011, 5'd9,  1'b0, 1'b0};
    tbl[6]  = '{1'b1, 7'b0110011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b101, 5'd10, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 7'b0010011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 5'd11, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 7'b0010011, 3'b111, 1'b0, 5'd1, 5'd2, 5'd12, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010, 5'd12, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 7'b0010011, 3'b010, 1'b1, 5'd1, 5'd2, 5'd13, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b101, 5'd13, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0,  2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 5'd0,  1'b0, 1'b0};
    tbl[11] = '{1'b1, 7'b0000000, 3'b000, 1'b0, 5'd1, 5'd2, 5'd14, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0,  1'b1, 1'b0};
    tbl[12] = '{1'b0, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd15, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0,  1'b0, 1'b0};
    tbl[13] = '{1'b1, 7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1,  2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 5'd1,  1'b0, 1'b1};
    tbl[14] = '{1'b0, 7'b0000000, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0,  1'b0, 1'b0};
    tbl[15] = tbl[14];
    tbl[16] = tbl[14];

    // reset state
    rst_n = 1'b0;
    ex_eq = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    chk("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
    chk("rst_mem_reg_write", 32'(mem_reg_write), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_stall_f", 32'(stall_f), 32'd0);
    chk("rst_flush_e", 32'(flush_e), 32'd0);
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("rst_z_stall_f", 32'(z_stall_f), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bubbles(3);

    // decode table with pipeline scoreboard
    for (int i = 0; i < NV; i++) begin
      t = tbl[i];
      drive(t.v, t.op, t.f3, t.f7, t.rs1, t.rs2, t.rd);
      ex_eq = 1'b0;
      #1;
      chk($sformatf("imm_src[%0d]", i), 32'(imm_src), 32'(t.imm));
      e = '{t.rw, t.mw, t.as, t.br, t.jp, t.rsrc, t.alu, t.erd, t.ill};
      pipe_q.push_back(e);
      tick();
      e = pipe_q[pipe_q.size()-1];
      chk($sformatf("ex_bundle[%0d]", i),
          32'({ex_reg_write, ex_mem_write, ex_alu_src, ex_branch, ex_jump,
               ex_result_src, ex_alu_ctrl, ex_rd, ex_illegal}),
          32'({e.rw, e.mw, e.as, e.br, e.jp, e.rsrc, e.alu, e.rd, e.ill}));
      chk($sformatf("pc_src[%0d]", i), 32'(pc_src), 32'(t.pc));
      if (pipe_q.size() >= 2) begin
        e = pipe_q[pipe_q.size()-2];
        chk($sformatf("mem_bundle[%0d]", i),
            32'({mem_reg_write, mem_mem_write, mem_result_src, mem_rd}),
            32'({e.rw, e.mw, e.rsrc, e.rd}));
      end
      if (pipe_q.size() == 3) begin
        e = pipe_q.pop_front();
        chk($sformatf("wb_bundle[%0d]", i),
            32'({wb_reg_write, wb_result_src, wb_rd}),
            32'({e.rw, e.rsrc, e.rd}));
      end
    end
    pipe_q.delete();

    // forwarding: add x3,x1,x2 ; sub x4,x3,x1 ; or x5,x3,x0
    bubbles(3);
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3);
    tick();
    drive(1'b1, 7'b0110011, 3'b000, 1'b1, 5'd3, 5'd1, 5'd4);
    #1;
    chk("fwd_sub_no_stall", 32'(stall_f), 32'd0);
    tick();
    chk("fwd_sub_alu", 32'(ex_alu_ctrl), 32'd1);
    chk("fwd_sub_fwd_a", 32'(fwd_a), 32'd2);
    chk("fwd_sub_fwd_b", 32'(fwd_b), 32'd0);
    drive(1'b1, 7'b0110011, 3'b110, 1'b0, 5'd3, 5'd0, 5'd5);
    tick();
    chk("fwd_or_fwd_a", 32'(fwd_a), 32'd1);
    chk("fwd_or_fwd_b", 32'(fwd_b), 32'd0);
    chk("fwd_or_alu", 32'(ex_alu_ctrl), 32'd3);

    // load-use: lw x5,0(x1) ; add x6,x5,x2
    bubbles(3);
    drive(1'b1, 7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5);
    tick();
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 5'd5, 5'd2, 5'd6);
    #1;
    chk("lu_stall_f", 32'(stall_f), 32'd1);
    chk("lu_stall_d", 32'(stall_d), 32'd1);
    chk("lu_flush_e", 32'(flush_e), 32'd1);
    chk("lu_flush_d", 32'(flush_d), 32'd0);
    tick();
    chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    chk("lu_bubble_rd", 32'(ex_rd), 32'd0);
    chk("lu_stall_released", 32'(stall_f), 32'd0);
    tick();
    chk("lu_add_in_ex", 32'(ex_rd), 32'd6);
    chk("lu_add_fwd_a", 32'(fwd_a), 32'd1);
    chk("lu_add_fwd_b", 32'(fwd_b), 32'd0);

    // branches and redirect flush
    bubbles(3);
    drive(1'b1, 7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd7);
    ex_eq = 1'b1;
    #1;
    chk("beq_eq_pc_src", 32'(pc_src), 32'd1);
    chk("beq_eq_flush", 32'({flush_d, flush_e}), 32'd3);
    chk("beq_eq_no_stall", 32'(stall_f), 32'd0);
    tick();
    chk("beq_flushed_ex", 32'({ex_reg_write, ex_rd}), 32'd0);
    ex_eq = 1'b0;
    drive(1'b1, 7'b1100011, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("bne_ne_pc_src", 32'(pc_src), 32'd1);
    chk("bne_ne_flush_d", 32'(flush_d), 32'd1);
    tick();
    drive(1'b1, 7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("beq_ne_pc_src", 32'(pc_src), 32'd0);
    chk("beq_ne_flush", 32'({flush_d, flush_e}), 32'd0);

    // stall-only variant: add x3 then dependent add -> two stall cycles
    bubbles(3);
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3);
    tick();
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 5'd3, 5'd2, 5'd7);
    #1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (z_stall_f !== 1'b1) break;
      n++;
      tick();
    end
    chk("nofwd_stall_cycles", 32'(n), 32'd2);
    tick();
    chk("nofwd_dep_in_ex", 32'(z_ex_rd), 32'd7);
    chk("nofwd_fwd_a", 32'(z_fwd_a), 32'd0);

    // writes to x0 never stall or forward
    bubbles(3);
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7);
    #1;
    chk("x0_no_stall_ex", 32'(z_stall_f), 32'd0);
    tick();
    chk("x0_dep_in_ex", 32'(z_ex_rd), 32'd7);
    chk("x0_no_fwd", 32'({fwd_a, fwd_b}), 32'd0);

    // illegal opcode in the stall-only variant
    bubbles(3);
    drive(1'b1, 7'b0000000, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3);
    tick();
    chk("ill_flag", 32'(z_ex_illegal), 32'd1);
    chk("ill_no_rw", 32'(z_ex_reg_write), 32'd0);
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("ill_one_cycle", 32'(z_ex_illegal), 32'd0);

    // redirect overrides a pending stall: lw x5 in MEM, taken beq in EX, add x6,x5,x2 in ID
    bubbles(3);
    drive(1'b1, 7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5);
    tick();
    drive(1'b1, 7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0);
    #1;
    chk("prio_beq_no_stall", 32'(z_stall_f), 32'd0);
    tick();
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 5'd5, 5'd2, 5'd6);
    ex_eq = 1'b0;
    #1;
    chk("prio_stall_when_not_taken", 32'(z_stall_f), 32'd1);
    ex_eq = 1'b1;
    #1;
    chk("prio_pc_src", 32'(z_pc_src), 32'd1);
    chk("prio_stall", 32'({z_stall_f, z_stall_d}), 32'd0);
    chk("prio_flush", 32'({z_flush_d, z_flush_e}), 32'd3);
    ex_eq = 1'b0;

    // reset mid-stream
    bubbles(3);
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3);
    tick();
    tick();
    tick();
    chk("mid_pre_wb_rw", 32'(wb_reg_write), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_ex_cleared", 32'({ex_reg_write, ex_rd}), 32'd0);
    chk("mid_mem_cleared", 32'({mem_reg_write, mem_rd}), 32'd0);
    chk("mid_wb_cleared", 32'({wb_reg_write, wb_rd}), 32'd0);
    chk("mid_z_wb_cleared", 32'(z_wb_reg_write), 32'd0);
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("post_rst_wb_rw[%0d]", c), 32'(wb_reg_write), 32'd0);
      chk($sformatf("post_rst_stall[%0d]", c), 32'({stall_f, stall_d, z_stall_f}), 32'd0);
      chk($sformatf("post_rst_ex_rw[%0d]", c), 32'(ex_reg_write), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
